// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock FIFO: count width, threshold legality
// and the per-cycle request decision record.
package sync_fifo_pkg;

   typedef struct packed {
      logic write_accept;
      logic read_accept;
      logic overflow_event;
      logic underflow_event;
   } fifo_access_t;

   function automatic int count_width(input int address_width);
      return address_width + 1;
   endfunction

   function automatic bit thresholds_legal(
      input int address_width,
      input int almost_full_threshold,
      input int almost_empty_threshold
   );
      int depth;
      depth = 1 << address_width;
      return (almost_full_threshold >= 1) && (almost_full_threshold <= depth) &&
             (almost_empty_threshold >= 0) && (almost_empty_threshold <= depth - 1);
   endfunction

endpackage

// File: rtl/sync_fifo_memory.sv
// FIFO storage array: synchronous write, combinational read, never cleared.
module sync_fifo_memory
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 4
)(
   input  logic                     i_clock,
   input  logic                     i_write_enable,
   input  logic [ADDRESS_WIDTH-1:0] i_write_address,
   input  logic [DATA_WIDTH-1:0]    i_write_data,
   input  logic [ADDRESS_WIDTH-1:0] i_read_address,
   output logic [DATA_WIDTH-1:0]    o_read_data
);

   localparam int DEPTH = 1 << ADDRESS_WIDTH;

   logic [DATA_WIDTH-1:0] r_storage [0:DEPTH-1];

   always_ff @(posedge i_clock) begin
      if (i_write_enable) begin
         r_storage[i_write_address] <= i_write_data;
      end
   end

   assign o_read_data = r_storage[i_read_address];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with selectable FWFT/standard read, almost flags,
// occupancy count and sticky overflow/underflow flags.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH             = 8,
   parameter int ADDRESS_WIDTH          = 4,
   parameter bit FWFT                   = 1'b1,
   parameter int ALMOST_FULL_THRESHOLD  = (1 << ADDRESS_WIDTH) - 2,
   parameter int ALMOST_EMPTY_THRESHOLD = 2
)(
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [DATA_WIDTH-1:0]                 write_data,
   input  logic                                  write_increment,
   output logic                                  full,
   output logic                                  almost_full,
   input  logic                                  read_increment,
   output logic [DATA_WIDTH-1:0]                 read_data,
   output logic                                  empty,
   output logic                                  almost_empty,
   output logic [count_width(ADDRESS_WIDTH)-1:0] count,
   output logic                                  overflow,
   output logic                                  underflow
);

   localparam int CW = count_width(ADDRESS_WIDTH);
   localparam logic [CW-1:0] AF_LIMIT = CW'(ALMOST_FULL_THRESHOLD);
   localparam logic [CW-1:0] AE_LIMIT = CW'(ALMOST_EMPTY_THRESHOLD);
   localparam logic [CW-1:0] PTR_STEP = CW'(1);

   generate
      if (!thresholds_legal(ADDRESS_WIDTH, ALMOST_FULL_THRESHOLD, ALMOST_EMPTY_THRESHOLD)) begin : g_illegal_thresholds
         $error("sync_fifo: almost-full/almost-empty threshold out of range");
      end
   endgenerate

   logic [CW-1:0]         r_write_pointer;
   logic [CW-1:0]         r_read_pointer;
   logic                  r_overflow;
   logic                  r_underflow;
   logic [CW-1:0]         w_count;
   logic                  w_empty;
   logic                  w_full;
   logic [DATA_WIDTH-1:0] w_memory_read_data;
   fifo_access_t          w_access;

   // MSB is the wrap bit: equal pointers mean empty, differing wrap bits over equal addresses mean full.
   assign w_count = r_write_pointer - r_read_pointer;
   assign w_empty = (r_write_pointer == r_read_pointer);
   assign w_full  = (r_write_pointer[CW-1] != r_read_pointer[CW-1]) &&
                    (r_write_pointer[CW-2:0] == r_read_pointer[CW-2:0]);

   // Decide acceptance from the pre-edge state so full/empty never pass data through.
   always_comb begin
      w_access                 = '0;
      w_access.write_accept    = write_increment && !w_full;
      w_access.read_accept     = read_increment && !w_empty;
      w_access.overflow_event  = write_increment && w_full;
      w_access.underflow_event = read_increment && w_empty;
   end

   // Pointer advance and sticky error capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_write_pointer <= '0;
         r_read_pointer  <= '0;
         r_overflow      <= 1'b0;
         r_underflow     <= 1'b0;
      end else begin
         if (w_access.write_accept) begin
            r_write_pointer <= r_write_pointer + PTR_STEP;
         end
         if (w_access.read_accept) begin
            r_read_pointer <= r_read_pointer + PTR_STEP;
         end
         r_overflow  <= r_overflow  | w_access.overflow_event;
         r_underflow <= r_underflow | w_access.underflow_event;
      end
   end

   sync_fifo_memory #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
   ) u_memory (
      .i_clock         (clock),
      .i_write_enable  (w_access.write_accept && !reset),
      .i_write_address (r_write_pointer[CW-2:0]),
      .i_write_data    (write_data),
      .i_read_address  (r_read_pointer[CW-2:0]),
      .o_read_data     (w_memory_read_data)
   );

   generate
      if (FWFT) begin : g_fwft
         assign read_data = w_empty ? '0 : w_memory_read_data;
      end else begin : g_standard
         logic [DATA_WIDTH-1:0] r_read_data;

         // Standard mode: capture the dequeued word, hold otherwise.
         always_ff @(posedge clock) begin
            if (reset) begin
               r_read_data <= '0;
            end else if (w_access.read_accept) begin
               r_read_data <= w_memory_read_data;
            end else begin
               r_read_data <= r_read_data;
            end
         end

         assign read_data = r_read_data;
      end
   endgenerate

   assign count        = w_count;
   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_full  = (w_count >= AF_LIMIT);
   assign almost_empty = (w_count <= AE_LIMIT);
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: FWFT and standard instances share stimulus and are
// checked every cycle against a queue model, plus literal expectations.
module tb_sync_fifo;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       wi    = 1'b0;
   logic       ri    = 1'b0;
   logic [7:0] wd    = 8'h00;

   always #5 clock = ~clock;

   logic       f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
   logic [7:0] f_rd;
   logic [2:0] f_count;
   logic       s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
   logic [7:0] s_rd;
   logic [2:0] s_count;

   sync_fifo #(.DATA_WIDTH(8), .ADDRESS_WIDTH(2), .FWFT(1'b1),
               .ALMOST_FULL_THRESHOLD(3), .ALMOST_EMPTY_THRESHOLD(1)) dut_f (
      .clock(clock), .reset(reset), .write_data(wd), .write_increment(wi),
      .full(f_full), .almost_full(f_af), .read_increment(ri), .read_data(f_rd),
      .empty(f_empty), .almost_empty(f_ae), .count(f_count),
      .overflow(f_ovf), .underflow(f_unf));

   sync_fifo #(.DATA_WIDTH(8), .ADDRESS_WIDTH(2), .FWFT(1'b0),
               .ALMOST_FULL_THRESHOLD(3), .ALMOST_EMPTY_THRESHOLD(1)) dut_s (
      .clock(clock), .reset(reset), .write_data(wd), .write_increment(wi),
      .full(s_full), .almost_full(s_af), .read_increment(ri), .read_data(s_rd),
      .empty(s_empty), .almost_empty(s_ae), .count(s_count),
      .overflow(s_ovf), .underflow(s_unf));

   // Model: contents queue, sticky flags, last dequeued word.
   logic [7:0] q[$];
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;
   logic [7:0] m_std = 8'h00;
   bit         model_valid = 1'b0;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic cycle(input logic rst, input logic w, input logic [7:0] d, input logic r);
      bit was_full;
      bit was_empty;
      reset = rst;
      wi    = w;
      wd    = d;
      ri    = r;
      @(posedge clock);
      if (rst) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_std = 8'h00;
         model_valid = 1'b1;
      end else begin
         was_full  = (q.size() == 4);
         was_empty = (q.size() == 0);
         if (w && was_full)  m_ovf = 1'b1;
         if (r && was_empty) m_unf = 1'b1;
         if (r && !was_empty) m_std = q.pop_front();
         if (w && !was_full) q.push_back(d);
      end
      #1;
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clock) begin
      if (model_valid) begin
         automatic int n = q.size();
         automatic logic [7:0] head = (n == 0) ? 8'h00 : q[0];
         check("f_count", f_count, n);
         check("s_count", s_count, n);
         check("f_empty", f_empty, n == 0);
         check("s_empty", s_empty, n == 0);
         check("f_full", f_full, n == 4);
         check("s_full", s_full, n == 4);
         check("f_almost_full", f_af, n >= 3);
         check("s_almost_full", s_af, n >= 3);
         check("f_almost_empty", f_ae, n <= 1);
         check("s_almost_empty", s_ae, n <= 1);
         check("f_overflow", f_ovf, m_ovf);
         check("s_overflow", s_ovf, m_ovf);
         check("f_underflow", f_unf, m_unf);
         check("s_underflow", s_unf, m_unf);
         check("f_read_data", f_rd, head);
         check("s_read_data", s_rd, m_std);
      end
   end

   initial begin
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      check("lit_reset_count", f_count, 0);
      check("lit_reset_empty", s_empty, 1);
      check("lit_reset_rd", s_rd, 8'h00);

      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 8'hA1 + 8'(i), 1'b0);
         check("lit_fill_count", f_count, i + 1);
         check("lit_fill_af", f_af, i >= 2);
         check("lit_fill_ae", s_ae, i == 0);
         check("lit_fill_full", s_full, i == 3);
      end

      cycle(1'b0, 1'b1, 8'hA5, 1'b0);
      check("lit_overflow", f_ovf, 1);
      check("lit_overflow_count", s_count, 4);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      check("lit_overflow_sticky", s_ovf, 1);

      for (int i = 0; i < 4; i++) begin
         check("lit_fwft_head", f_rd, 8'hA1 + 8'(i));
         cycle(1'b0, 1'b0, 8'h00, 1'b1);
         check("lit_std_drain", s_rd, 8'hA1 + 8'(i));
      end
      check("lit_drain_empty", f_empty, 1);
      check("lit_fwft_empty_zero", f_rd, 8'h00);

      cycle(1'b0, 1'b1, 8'h5C, 1'b0);
      check("lit_fwft_visible", f_rd, 8'h5C);
      check("lit_fwft_not_empty", f_empty, 0);
      check("lit_std_hold", s_rd, 8'hA4);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check("lit_std_read", s_rd, 8'h5C);

      check("lit_no_underflow", f_unf, 0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check("lit_underflow", s_unf, 1);
      check("lit_underflow_count", f_count, 0);
      cycle(1'b0, 1'b1, 8'h33, 1'b1);
      check("lit_empty_both_count", s_count, 1);
      check("lit_empty_both_head", f_rd, 8'h33);
      check("lit_empty_both_std", s_rd, 8'h5C);
      cycle(1'b0, 1'b1, 8'h34, 1'b0);

      for (int p = 0; p < 10; p++) begin
         cycle(1'b0, 1'b1, 8'h40 + 8'(p), 1'b1);
         check("lit_pair_count", f_count, 2);
         check("lit_pair_std", s_rd, (p == 0) ? 8'h33 : (p == 1) ? 8'h34 : 8'h40 + 8'(p - 2));
         check("lit_pair_head", f_rd, (p == 0) ? 8'h34 : 8'h40 + 8'(p - 1));
      end

      cycle(1'b0, 1'b1, 8'h60, 1'b0);
      check("lit_pre_reset_count", s_count, 3);
      cycle(1'b1, 1'b1, 8'h77, 1'b1);
      check("lit_mid_reset_count", f_count, 0);
      check("lit_mid_reset_empty", s_empty, 1);
      check("lit_mid_reset_ovf", f_ovf, 0);
      check("lit_mid_reset_unf", s_unf, 0);
      check("lit_mid_reset_rd", s_rd, 8'h00);

      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b1, 8'h80 + 8'(i), 1'b0);
      end
      check("lit_refill_full", f_full, 1);
      cycle(1'b0, 1'b1, 8'h88, 1'b1);
      check("lit_full_both_count", s_count, 3);
      check("lit_full_both_ovf", f_ovf, 1);
      check("lit_full_both_std", s_rd, 8'h80);
      check("lit_full_both_head", f_rd, 8'h81);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 8'h00, 1'b1);
      end
      check("lit_final_std", s_rd, 8'h83);
      check("lit_final_unf", f_unf, 1);

      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
